// File: rtl/om_ds_writeback.sv
// OM depth/stencil write-back: serializes per-lane merged depth/stencil results into memory writes.
// Optional perf counters (perf_writes, perf_stalls) are enabled by defining VX_OM_DS_WB_PERF_EN.
module om_ds_writeback #(
  parameter int NUM_LANES   = 4,
  parameter int TAG_WIDTH   = 1,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            dcrs_depth_writemask,
  input  logic [15:0]                     dcrs_stencil_writemask,
  input  logic                            valid_in,
  output logic                            ready_in,
  input  logic [TAG_WIDTH-1:0]            tag_in,
  input  logic [NUM_LANES-1:0]            lane_mask,
  input  logic [NUM_LANES-1:0]            face,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] addr_in,
  input  logic [NUM_LANES*24-1:0]         depth_in,
  input  logic [NUM_LANES*8-1:0]          stencil_in,
  output logic                            mem_req_valid,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr,
  output logic [31:0]                     mem_req_data,
  output logic [3:0]                      mem_req_byteen,
  input  logic                            mem_req_ready,
  input  logic                            mem_rsp_valid,
  output logic                            done_valid,
  output logic [TAG_WIDTH-1:0]            done_tag,
  input  logic                            done_ready,
  output logic                            idle
`ifdef VX_OM_DS_WB_PERF_EN
  ,
  output logic [31:0]                     perf_writes,
  output logic [31:0]                     perf_stalls
`endif
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PEND_W = $clog2(MAX_PENDING) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   wmask_q, wmask_d;
  logic [PEND_W-1:0]      pending_q, pending_d;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic [ADDR_WIDTH-1:0]  addr_q   [NUM_LANES];
  logic [31:0]            data_q   [NUM_LANES];
  logic [3:0]             byteen_q [NUM_LANES];

  logic [3:0]             be_in [NUM_LANES];
  logic [NUM_LANES-1:0]   wmask_in;
  logic [LANE_W-1:0]      sel;
  logic                   req_fire;
  logic                   rsp_ok;

  // Byte 3 carries stencil, bytes 2..0 carry depth.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      be_in[i]    = {(face[i] ? |dcrs_stencil_writemask[15:8] : |dcrs_stencil_writemask[7:0]),
                     {3{dcrs_depth_writemask}}};
      wmask_in[i] = lane_mask[i] && (be_in[i] != 4'b0000);
    end
  end

  always_comb begin
    sel = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (wmask_q[i]) sel = LANE_W'(i);
    end
  end

  assign mem_req_addr   = addr_q[sel];
  assign mem_req_data   = data_q[sel];
  assign mem_req_byteen = byteen_q[sel];
  assign done_tag       = tag_q;
  assign idle           = (state_q == S_IDLE) && (pending_q == '0);

  always_comb begin
    state_d       = state_q;
    wmask_d       = wmask_q;
    ready_in      = 1'b0;
    mem_req_valid = 1'b0;
    done_valid    = 1'b0;
    req_fire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_in = 1'b1;
        if (valid_in) begin
          wmask_d = wmask_in;
          state_d = (wmask_in == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_req_valid = (pending_q != PEND_W'(MAX_PENDING));
        req_fire      = mem_req_valid && mem_req_ready;
        if (req_fire) begin
          wmask_d = wmask_q & (wmask_q - NUM_LANES'(1));
          if (wmask_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_valid = 1'b1;
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A stray ack with nothing outstanding is dropped rather than underflowing.
  assign rsp_ok = mem_rsp_valid && (pending_q != '0);

  always_comb begin
    pending_d = pending_q;
    case ({req_fire, rsp_ok})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wmask_q   <= '0;
      pending_q <= '0;
      tag_q     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        byteen_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wmask_q   <= wmask_d;
      pending_q <= pending_d;
      if (ready_in && valid_in) begin
        tag_q <= tag_in;
        for (int i = 0; i < NUM_LANES; i++) begin
          addr_q[i]   <= addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
          data_q[i]   <= {stencil_in[i*8 +: 8], depth_in[i*24 +: 24]};
          byteen_q[i] <= be_in[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_rsp_valid) assert (pending_q != '0);
  end

`ifdef VX_OM_DS_WB_PERF_EN
  logic [31:0] perf_writes_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (req_fire) perf_writes_q <= perf_writes_q + 32'd1;
      if ((state_q == S_ISSUE) && !req_fire) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_om_ds_writeback.sv
// Bench for om_ds_writeback: request-queue/pending-count reference model plus directed latency,
// backpressure, pending-limit and mid-batch reset scenarios followed by randomized traffic.
module tb_om_ds_writeback;
  localparam int NL = 4;
  localparam int TW = 1;
  localparam int AW = 32;
  localparam int MP = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            dcrs_depth_writemask;
  logic [15:0]     dcrs_stencil_writemask;
  logic            valid_in;
  logic            ready_in;
  logic [TW-1:0]   tag_in;
  logic [NL-1:0]   lane_mask;
  logic [NL-1:0]   face;
  logic [NL*AW-1:0] addr_in;
  logic [NL*24-1:0] depth_in;
  logic [NL*8-1:0]  stencil_in;
  logic            mem_req_valid;
  logic [AW-1:0]   mem_req_addr;
  logic [31:0]     mem_req_data;
  logic [3:0]      mem_req_byteen;
  logic            mem_req_ready;
  logic            mem_rsp_valid;
  logic            done_valid;
  logic [TW-1:0]   done_tag;
  logic            done_ready;
  logic            idle;

  always #5 clk = ~clk;

  om_ds_writeback #(.NUM_LANES(NL), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .dcrs_depth_writemask(dcrs_depth_writemask), .dcrs_stencil_writemask(dcrs_stencil_writemask),
    .valid_in(valid_in), .ready_in(ready_in), .tag_in(tag_in), .lane_mask(lane_mask), .face(face),
    .addr_in(addr_in), .depth_in(depth_in), .stencil_in(stencil_in),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_byteen(mem_req_byteen), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .done_valid(done_valid), .done_tag(done_tag), .done_ready(done_ready), .idle(idle)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: outstanding writes of the current batch, in issue order.
  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } req_t;

  req_t          reqq[$];
  bit            busy = 1'b0;
  logic [TW-1:0] tag_m = '0;
  int            pend = 0;
  int            fires_dut = 0;
  bit            started = 1'b0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  logic [3:0]    prev_be;

  always @(posedge clk) started <= 1'b1;

  always @(negedge clk) begin
    bit   expv, expd, fire, rsp, dfire;
    req_t r;
    logic [7:0] sm;
    expv = (reqq.size() > 0) && (pend < MP);
    expd = busy && (reqq.size() == 0);
    if (started) begin
      chk("req_valid", mem_req_valid, expv);
      chk("done_valid", done_valid, expd);
      chk("ready_in", ready_in, !busy);
      chk("idle", idle, (!busy && pend == 0));
      if (expv) begin
        chk("req_addr", mem_req_addr, reqq[0].addr);
        chk("req_data", mem_req_data, reqq[0].data);
        chk("req_byteen", mem_req_byteen, reqq[0].be);
      end
      if (expd) chk("done_tag", done_tag, tag_m);
      if (prev_stall) begin
        chk("hold_addr", mem_req_addr, prev_addr);
        chk("hold_data", mem_req_data, prev_data);
        chk("hold_byteen", mem_req_byteen, prev_be);
      end
    end
    prev_stall = started && reset && mem_req_valid && !mem_req_ready;
    prev_addr = mem_req_addr;
    prev_data = mem_req_data;
    prev_be = mem_req_byteen;
    if (started && reset && mem_req_valid && mem_req_ready) fires_dut++;

    if (!reset) begin
      busy = 1'b0;
      reqq.delete();
      pend = 0;
    end else if (started) begin
      fire  = expv && mem_req_ready;
      rsp   = mem_rsp_valid && (pend > 0);
      dfire = expd && done_ready;
      if (fire) void'(reqq.pop_front());
      pend = pend + (fire ? 1 : 0) - (rsp ? 1 : 0);
      if (dfire) busy = 1'b0;
      else if (!busy && valid_in) begin
        busy  = 1'b1;
        tag_m = tag_in;
        for (int i = 0; i < NL; i++) begin
          sm     = face[i] ? dcrs_stencil_writemask[15:8] : dcrs_stencil_writemask[7:0];
          r.be   = {(sm != 8'h00), {3{dcrs_depth_writemask}}};
          r.addr = addr_in[i*AW +: AW];
          r.data = {stencil_in[i*8 +: 8], depth_in[i*24 +: 24]};
          if (lane_mask[i] && r.be != 4'h0) reqq.push_back(r);
        end
      end
    end
  end

  task automatic set_batch(logic [3:0] lm, logic [3:0] fc, logic dm, logic [7:0] fm, logic [7:0] bm,
                           logic [TW-1:0] t);
    lane_mask = lm;
    face = fc;
    dcrs_depth_writemask = dm;
    dcrs_stencil_writemask = {bm, fm};
    tag_in = t;
    for (int i = 0; i < NL; i++) begin
      addr_in[i*AW +: AW]    = $urandom & 32'hFFFF_FFFC;
      depth_in[i*24 +: 24]   = 24'($urandom);
      stencil_in[i*8 +: 8]   = 8'($urandom);
    end
  endtask

  task automatic run_batch(string name, int k_exp, logic [3:0] exp_be, int exp_lane);
    int n;
    logic [TW-1:0] t;
    t = tag_in;
    @(posedge clk); #1 valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_in && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    if (k_exp > 0) begin
      chk({name, "_be"}, mem_req_byteen, exp_be);
      chk({name, "_addr"}, mem_req_addr, addr_in[exp_lane*AW +: AW]);
    end
    n = 0;
    while (!done_valid && n < 200) begin @(negedge clk); n++; end
    chk({name, "_latency"}, n, k_exp);
    chk({name, "_tag"}, done_tag, t);
    @(posedge clk); #1 done_ready = 1'b1;
    @(posedge clk); #1 done_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_req_ready = 1'b1;
    valid_in = 1'b0;
    while ((pend > 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      mem_rsp_valid = (pend > 0) && ($urandom % 2 == 1);
      done_ready = 1'b1;
      n++;
    end
    @(posedge clk); #1 mem_rsp_valid = 1'b0; done_ready = 1'b0;
    @(negedge clk);
    chk("drain_idle", idle, 1'b1);
  endtask

  initial begin
    int f0, n;
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, n;
    reset = 1'b0;
    valid_in = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; done_ready = 1'b0;
    set_batch(4'h0, 4'h0, 1'b0, 8'h00, 8'h00, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_done_valid", done_valid, 1'b0);
    chk("rst_ready_in", ready_in, 1'b1);
    chk("rst_idle", idle, 1'b1);
    @(posedge clk); #1 reset = 1'b1;

    // Full batch, all bytes written.
    set_batch(4'b1111, 4'($urandom), 1'b1, 8'hFF, 8'hFF, 1'b1);
    run_batch("full", 4, 4'hF, 0);
    // Only lane 3 (back face) writes stencil.
    set_batch(4'b1010, 4'b1000, 1'b0, 8'h00, 8'h0F, 1'b0);
    run_batch("lane3", 1, 4'b1000, 3);
    drain();
    // Nothing to write.
    set_batch(4'b0000, 4'($urandom), 1'b1, 8'hFF, 8'hFF, 1'b1);
    run_batch("empty", 0, 4'h0, 0);

    // Pending limit with no acks.
    drain();
    f0 = fires_dut;
    set_batch(4'b1111, 4'($urandom), 1'b1, 8'hFF, 8'hFF, 1'b0);
    done_ready = 1'b1;
    @(posedge clk); #1 valid_in = 1'b1;
    repeat (30) @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    chk("limit_fires", fires_dut - f0, 8);
    chk("limit_req_valid", mem_req_valid, 1'b0);
    chk("limit_ready_in", ready_in, 1'b0);
    f0 = fires_dut;
    @(posedge clk); #1 mem_rsp_valid = 1'b1;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("one_ack_one_fire", fires_dut - f0, 1);
    f0 = fires_dut;
    @(posedge clk); #1 mem_rsp_valid = 1'b1;
    @(posedge clk); #1 mem_rsp_valid = 1'b1;
    @(posedge clk); #1 mem_rsp_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ack_with_fire", fires_dut - f0, 2);
    chk("ack_with_fire_valid", mem_req_valid, 1'b0);
    drain();

    // Toggling backpressure with several batches.
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (c % 8 == 0) set_batch(4'($urandom), 4'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      valid_in = (c < 50);
      mem_req_ready = c[0];
      mem_rsp_valid = (pend > 0) && ($urandom % 2 == 1);
      done_ready = 1'b1;
    end
    drain();

    // Reset in the middle of an issuing batch with three writes outstanding.
    set_batch(4'b1111, 4'($urandom), 1'b1, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1 valid_in = 1'b1;
    n = 0;
    while (pend != 3 && n < 50) begin @(posedge clk); #1 valid_in = 1'b0; n++; end
    mem_req_ready = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    chk("midrst_done_valid", done_valid, 1'b0);
    chk("midrst_ready_in", ready_in, 1'b1);
    chk("midrst_idle", idle, 1'b1);
    @(posedge clk); #1 reset = 1'b1; mem_req_ready = 1'b1;

    // Randomized traffic, DCRs and handshakes changing every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      set_batch(4'($urandom), 4'($urandom), 1'($urandom),
                ($urandom % 3 == 0) ? 8'h00 : 8'($urandom),
                ($urandom % 3 == 0) ? 8'h00 : 8'($urandom), 1'($urandom));
      valid_in = ($urandom % 3) != 0;
      mem_req_ready = ($urandom % 4) != 0;
      mem_rsp_valid = (pend > 0) && ($urandom % 2 == 1);
      done_ready = ($urandom % 2 == 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/om_ds_writeback.md
Name: om_ds_writeback

Overview:
- Write-back end of the OM depth/stencil path: consumes per-lane merged depth/stencil results from the depth/stencil test stage and serializes them into framebuffer memory write requests.
- One lane is issued per cycle, with byte enables derived from the depth/stencil write masks; lanes with nothing to write are skipped.
- Tracks outstanding write acks and signals batch completion to the OM core via a tagged done handshake.

Parameters:
NUM_LANES, 4, lanes per input batch
TAG_WIDTH, 1, batch tag width carried to the done port
ADDR_WIDTH, 32, byte address width of the memory write port
MAX_PENDING, 8, max un-acked memory writes (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
dcrs_depth_writemask  in  1  depth write enable
dcrs_stencil_writemask  in  2x8  stencil write mask per face (0 = front, 1 = back)
valid_in  in  1  batch valid
ready_in  out  1  batch accept
tag_in  in  TAG_WIDTH  batch tag
lane_mask  in  NUM_LANES  active lanes
face  in  NUM_LANES  per-lane face select
addr_in  in  NUM_LANES x ADDR_WIDTH  per-lane word-aligned byte address
depth_in  in  NUM_LANES x 24  merged depth
stencil_in  in  NUM_LANES x 8  merged stencil
mem_req_valid  out  1  write request valid
mem_req_addr  out  ADDR_WIDTH  write address
mem_req_data  out  32  {stencil[7:0], depth[23:0]}
mem_req_byteen  out  4  byte enables
mem_req_ready  in  1  memory accept
mem_rsp_valid  in  1  one write ack (always accepted)
done_valid  out  1  batch fully issued
done_tag  out  TAG_WIDTH  tag of completed batch
done_ready  in  1  done accept
idle  out  1  IDLE state and zero pending writes

Behaviour:
- Reset (reset == 0 at a clock edge): state = IDLE, pending = 0. Output values while in reset / after reset: mem_req_valid = 0, done_valid = 0, ready_in = 1, idle = 1. Data outputs (addr, data, byteen, tag) are don't-care, registered values cleared to 0.
- Per-lane byte enables: byteen = {|stencil_writemask[face], dmask, dmask, dmask}, where dmask = dcrs_depth_writemask.
- Per-lane write condition: lane_mask[i] && byteen_i != 0.
- FSM IDLE:
  - ready_in = 1.
  - On valid_in: register all inputs and the per-lane write bitmask wmask.
  - wmask == 0 -> DONE, else -> ISSUE.
- FSM ISSUE:
  - ready_in = 0.
  - Present the lowest set bit of wmask on the mem_req outputs (combinational from registered state).
  - mem_req_valid = !(pending == MAX_PENDING).
  - On a request fire: clear that bit; if it was the last bit -> DONE.
  - Request outputs hold stable while valid and not ready.
- FSM DONE:
  - done_valid = 1, done_tag = registered tag.
  - On done_ready -> IDLE. No bypass: the next batch is accepted the cycle after the done fire.
- Latency: batch accepted at cycle t, first request at t+1. With k lanes written and no backpressure, done_valid rises at t+1+k; with k = 0, at t+1.
- Pending counter:
  - Increments on request fire, decrements on mem_rsp_valid; both in the same cycle -> unchanged.
  - Never exceeds MAX_PENDING; a response at pending == 0 is ignored (assertion).
- Issue order is ascending lane index. Lanes with lane_mask = 0 or byteen = 0 consume no cycles.
- DCRs are sampled at batch accept; DCR changes mid-batch do not affect that batch.

Optional Feature:
- Macro VX_OM_DS_WB_PERF_EN.
- Defined: adds outputs perf_writes (32-bit count of fired mem requests) and perf_stalls (32-bit count of cycles in ISSUE without a fire). Both counters reset to 0 and wrap on overflow.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Batch with lane_mask = 4'b1111, depth_writemask = 1, stencil masks = 8'hFF, mem_req_ready held 1 -> 4 requests on consecutive cycles, lanes 0..3, byteen = 4'hF, data = {stencil, depth}; done_valid at accept+5.
- lane_mask = 4'b1010, depth_writemask = 0, front mask = 0, back mask = 8'h0F, face = 4'b1000 -> exactly one request (lane 3), byteen = 4'b1000; done at accept+2.
- All lanes masked off -> no requests; done_valid at accept+1 with matching tag; ready_in stays 0 until done fires.
- MAX_PENDING = 8, no acks, two full batches -> 8 requests issue, then mem_req_valid = 0. One mem_rsp_valid -> exactly one more request. Ack coinciding with a fire leaves pending unchanged.
- mem_req_ready toggled 0/1 every cycle -> addr/data/byteen stable while stalled; no lane dropped or duplicated.
- Assert reset (0) mid-ISSUE with pending = 3 -> next cycle mem_req_valid = 0, done_valid = 0, ready_in = 1, idle = 1.
